// File: rtl/match_logger.sv
// Timestamped match-event logger: stamps each detection pulse with a free-running
// counter, queues the stamps in a first-word-fall-through FIFO and keeps match statistics.
module match_logger #(
    parameter int DEPTH = 4,
    parameter int TSW   = 16,
    parameter int CNTW  = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         op,
    input  logic                         rd_en,
    output logic [TSW-1:0]               rd_data,
    output logic                         empty,
    output logic                         full,
    output logic [$clog2(DEPTH+1)-1:0]   level,
    output logic                         overflow,
    output logic [CNTW-1:0]              match_cnt
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = $clog2(DEPTH + 1);
    localparam logic [LW-1:0] LVL_FULL = LW'(DEPTH);

    logic [TSW-1:0]  ts_r;
    logic [TSW-1:0]  mem_r [DEPTH];
    logic [AW-1:0]   wr_ptr_r;
    logic [AW-1:0]   rd_ptr_r;
    logic [LW-1:0]   level_r;
    logic            overflow_r;
    logic [CNTW-1:0] match_cnt_r;

    logic            empty_s;
    logic            full_s;
    logic            pop_s;
    logic            push_s;
    logic            drop_s;
    logic [LW-1:0]   level_nxt_s;

    assign empty_s = (level_r == {LW{1'b0}});
    assign full_s  = (level_r == LVL_FULL);

    // Push/pop arbitration: a full FIFO still accepts a push when a pop frees a slot.
    always_comb begin
        pop_s       = rd_en && !empty_s;
        push_s      = op && (!full_s || pop_s);
        drop_s      = op && full_s && !pop_s;
        level_nxt_s = level_r;
        if (push_s && !pop_s) begin
            level_nxt_s = level_r + LW'(1);
        end else if (pop_s && !push_s) begin
            level_nxt_s = level_r - LW'(1);
        end else begin
            level_nxt_s = level_r;
        end
    end

    // Control state: timestamp, pointers, occupancy and statistics.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ts_r        <= {TSW{1'b0}};
            wr_ptr_r    <= {AW{1'b0}};
            rd_ptr_r    <= {AW{1'b0}};
            level_r     <= {LW{1'b0}};
            overflow_r  <= 1'b0;
            match_cnt_r <= {CNTW{1'b0}};
        end else begin
            ts_r    <= ts_r + TSW'(1);
            level_r <= level_nxt_s;
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            if (drop_s) begin
                overflow_r <= 1'b1;
            end
            // Dropped events still count; the counter sticks at all-ones.
            if (op && (match_cnt_r != {CNTW{1'b1}})) begin
                match_cnt_r <= match_cnt_r + CNTW'(1);
            end
        end
    end

    // Storage array; contents are meaningless until pointed at, so no reset needed.
    always_ff @(posedge clk) begin
        if (!rst && push_s) begin
            mem_r[wr_ptr_r] <= ts_r;
        end
    end

    assign empty     = empty_s;
    assign full      = full_s;
    assign level     = level_r;
    assign overflow  = overflow_r;
    assign match_cnt = match_cnt_r;
    assign rd_data   = empty_s ? {TSW{1'b0}} : mem_r[rd_ptr_r];

endmodule

// File: tb/tb_match_logger.sv
// Directed and randomized checks of match_logger against a queue-based reference model.
module tb_match_logger;

    logic        clk = 1'b0;
    logic        rst;
    logic        op;
    logic        rd_en;
    logic [15:0] rd_data;
    logic        empty;
    logic        full;
    logic [2:0]  level;
    logic        overflow;
    logic [7:0]  match_cnt;

    int vectors = 0;
    int miscompares = 0;

    // reference model state
    int q[$];
    int ts_m;
    int mcnt_m;
    int ovf_m;

    match_logger #(.DEPTH(4), .TSW(16), .CNTW(8)) dut (
        .clk(clk), .rst(rst), .op(op), .rd_en(rd_en),
        .rd_data(rd_data), .empty(empty), .full(full), .level(level),
        .overflow(overflow), .match_cnt(match_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        q.delete();
        ts_m = 0;
        mcnt_m = 0;
        ovf_m = 0;
    endtask

    task automatic model_edge(input logic o, input logic r);
        bit pop;
        pop = r && (q.size() > 0);
        if (pop) void'(q.pop_front());
        if (o) begin
            mcnt_m = (mcnt_m < 255) ? mcnt_m + 1 : 255;
            if (q.size() < 4) q.push_back(ts_m);
            else ovf_m = 1;
        end
        ts_m = (ts_m + 1) % 65536;
    endtask

    task automatic check_all(input string tag);
        int exp_rd;
        exp_rd = (q.size() > 0) ? q[0] : 0;
        chk({tag, ".empty"},     32'(empty),     32'(q.size() == 0));
        chk({tag, ".full"},      32'(full),      32'(q.size() == 4));
        chk({tag, ".level"},     32'(level),     32'(q.size()));
        chk({tag, ".rd_data"},   32'(rd_data),   32'(exp_rd));
        chk({tag, ".overflow"},  32'(overflow),  32'(ovf_m));
        chk({tag, ".match_cnt"}, 32'(match_cnt), 32'(mcnt_m));
    endtask

    task automatic step(input logic o, input logic r, input string tag);
        op = o;
        rd_en = r;
        @(posedge clk);
        model_edge(o, r);
        @(negedge clk);
        check_all(tag);
    endtask

    // hold reset across two edges with op/rd_en active; release on a falling edge
    task automatic do_reset();
        rst = 1'b1;
        op = 1'b1;
        rd_en = 1'b1;
        model_clear();
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        check_all("in_reset");
        rst = 1'b0;
        op = 1'b0;
        rd_en = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        op = 1'b0;
        rd_en = 1'b0;
        model_clear();
        @(negedge clk);
        do_reset();

        // single event at cycle 5
        for (int i = 0; i < 5; i++) step(1'b0, 1'b0, "idle");
        step(1'b1, 1'b0, "push5");
        chk("first_rd_data", 32'(rd_data), 32'd5);
        chk("first_level", 32'(level), 32'd1);
        chk("first_cnt", 32'(match_cnt), 32'd1);

        // fill to full then overflow, drain
        do_reset();
        for (int c = 0; c < 15; c++) step((c % 3 == 2) ? 1'b1 : 1'b0, 1'b0, "fill");
        chk("ovf_full", 32'(full), 32'd1);
        chk("ovf_level", 32'(level), 32'd4);
        chk("ovf_flag", 32'(overflow), 32'd1);
        chk("ovf_cnt", 32'(match_cnt), 32'd5);
        chk("ovf_head", 32'(rd_data), 32'd2);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, "drain");
        chk("drain_empty", 32'(empty), 32'd1);
        chk("drain_rd0", 32'(rd_data), 32'd0);
        step(1'b0, 1'b1, "pop_empty");
        chk("ovf_sticky", 32'(overflow), 32'd1);

        // push+pop while full
        do_reset();
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, "fill4");
        step(1'b1, 1'b1, "full_pushpop");
        chk("fpp_level", 32'(level), 32'd4);
        chk("fpp_ovf", 32'(overflow), 32'd0);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, "fpp_drain");

        // push+pop when empty, then sustained op with reads
        do_reset();
        step(1'b1, 1'b1, "empty_pushpop");
        chk("epp_level", 32'(level), 32'd1);
        for (int i = 0; i < 300; i++) step(1'b1, 1'b1, "stream");
        chk("sat_cnt", 32'(match_cnt), 32'd255);

        // randomized traffic
        for (int i = 0; i < 400; i++)
            step(($urandom % 3) == 0, ($urandom % 2) == 1, "rand");

        // timestamp wrap
        do_reset();
        op = 1'b0;
        rd_en = 1'b0;
        while (ts_m != 65535) begin
            @(posedge clk);
            model_edge(1'b0, 1'b0);
        end
        @(negedge clk);
        step(1'b1, 1'b0, "wrap_a");
        step(1'b1, 1'b0, "wrap_b");
        chk("wrap_head", 32'(rd_data), 32'd65535);
        step(1'b0, 1'b1, "wrap_pop");
        chk("wrap_next", 32'(rd_data), 32'd0);

        // asynchronous reset between edges with 3 entries and overflow set
        do_reset();
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, "ar_fill");
        step(1'b0, 1'b1, "ar_pop");
        chk("ar_pre_ovf", 32'(overflow), 32'd1);
        chk("ar_pre_level", 32'(level), 32'd3);
        #2;
        rst = 1'b1;
        model_clear();
        #1;
        check_all("async_rst");
        op = 1'b1;
        rd_en = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_all("rst_held");
        rst = 1'b0;
        op = 1'b0;
        rd_en = 1'b0;
        step(1'b0, 1'b0, "post_rst");
        chk("post_rst_empty", 32'(empty), 32'd1);
        step(1'b1, 1'b0, "post_rst_push");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/match_logger.md
MATCH_LOGGER -- requirements
Module: match_logger

Interface
REQ-001 The block SHALL have parameter DEPTH, default 4, meaning the event FIFO depth (power of two, at least 2).
REQ-002 The block SHALL have parameter TSW, default 16, meaning the timestamp width in bits.
REQ-003 The block SHALL have parameter CNTW, default 8, meaning the match-counter width in bits.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-006 The block SHALL have port op, input, 1 bit: the detection pulse from the upstream sequence detector; each cycle high is one match event.
REQ-007 The block SHALL have port rd_en, input, 1 bit: pop request from the consumer.
REQ-008 The block SHALL have port rd_data, output, TSW bits: the timestamp at the FIFO head (first-word-fall-through).
REQ-009 The block SHALL have port empty, output, 1 bit: high when the FIFO holds 0 entries.
REQ-010 The block SHALL have port full, output, 1 bit: high when the FIFO holds DEPTH entries.
REQ-011 The block SHALL have port level, output, clog2(DEPTH+1) bits: the current FIFO occupancy.
REQ-012 The block SHALL have port overflow, output, 1 bit: sticky flag set when an event is dropped.
REQ-013 The block SHALL have port match_cnt, output, CNTW bits: a saturating total of detected matches.

Function
REQ-014 Free-running timestamp ts SHALL be 0 in the first cycle after reset release, increment by 1 every clock, and wrap from 2^TSW-1 to 0.
REQ-015 When op is high at a rising edge, the value of ts in that same cycle SHALL be pushed, unless the push is dropped per REQ-019.
REQ-016 Pushed entries SHALL be visible on rd_data, with empty low, in the cycle after the push edge (1-cycle latency).
REQ-017 rd_data SHALL present the oldest entry whenever empty is low, and 0 whenever empty is high.
REQ-018 rd_en high with empty low SHALL remove the head at that edge; rd_en with empty high SHALL be ignored, with no state change.
REQ-019 A push with full high and no simultaneous valid pop SHALL be dropped: FIFO contents unchanged, overflow set.
REQ-020 Simultaneous push and pop when full SHALL both occur, leaving level at DEPTH and overflow unchanged.
REQ-021 Simultaneous push and pop when 0 < level < DEPTH SHALL leave level unchanged and preserve FIFO order.
REQ-022 Simultaneous op and rd_en when empty SHALL perform the push only; level SHALL become 1.
REQ-023 Pointers SHALL wrap modulo DEPTH; the FIFO order SHALL be strictly first-in first-out across wrap.
REQ-024 match_cnt SHALL increment on every op-high cycle, including dropped events, and saturate at 2^CNTW-1.
REQ-025 overflow SHALL remain high until reset; no other event SHALL clear it.
REQ-026 Back-to-back op-high cycles SHALL each be treated as separate events, even though the upstream guarantees a spacing of at least 3 cycles.
REQ-027 All outputs SHALL be registered or derived solely from registered state, with no combinational path from op or rd_en to any output.

Reset
REQ-028 Asserting rst SHALL immediately, without waiting for clk, clear ts, the pointers, level, overflow and match_cnt to 0, and force empty=1, full=0 and rd_data=0.
REQ-029 rst asserted mid-operation SHALL discard all FIFO contents; no pre-reset entry SHALL appear after release.
REQ-030 op and rd_en SHALL have no effect while rst is high.

Verification
REQ-031 Release reset, pulse op in cycle 5 -> next cycle empty=0, level=1, rd_data=5, match_cnt=1.
REQ-032 Pulse op in cycles 2, 5, 8, 11 with no reads, then pulse op in cycle 14 -> full=1, level=4, overflow=1, match_cnt=5; sequential reads return 2, 5, 8, 11, then empty=1 and rd_data=0.
REQ-033 With level=4, drive op and rd_en in the same cycle -> level stays 4, overflow stays 0, and the new timestamp is read last.
REQ-034 Hold op high for 300 consecutive cycles while reading every cycle -> match_cnt saturates at 255 and timestamps read are consecutive integers.
REQ-035 Run until ts=65535, pulse op at ts=65535 and at the next cycle -> reads return 65535, then 0.
REQ-036 Fill 3 entries with overflow set, then assert rst asynchronously between edges -> outputs clear before the next clk edge; after release, empty=1, overflow=0, match_cnt=0.
